// File: rtl/alu_share_if.sv
// alu_share_if: request, ALU and response bus of alu_share_ctrl.
// slave = controller side, master = requesters / ALU / consumer side.
// ALU_OVF_TRAP_EN adds the sticky ovf_trap signal.
interface alu_share_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_setf;
  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_setf;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_r;
  logic             alu_n;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_r;
  logic [3:0]       rsp_flags;
  logic [3:0]       status_nzcv;
  logic             busy;
`ifdef ALU_OVF_TRAP_EN
  logic             ovf_trap;
`endif

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_setf,
    input  req1_valid, req1_op, req1_a, req1_b, req1_setf,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_r, alu_n, alu_z, alu_c, alu_v,
    output rsp_valid, rsp_id, rsp_r, rsp_flags,
    input  rsp_ready,
`ifdef ALU_OVF_TRAP_EN
    output ovf_trap,
`endif
    output status_nzcv, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_setf,
    output req1_valid, req1_op, req1_a, req1_b, req1_setf,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_r, alu_n, alu_z, alu_c, alu_v,
    input  rsp_valid, rsp_id, rsp_r, rsp_flags,
    output rsp_ready,
`ifdef ALU_OVF_TRAP_EN
    input  ovf_trap,
`endif
    input  status_nzcv, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU between two
// requesters, with a registered operand bus, a held response channel and an
// architectural NZCV register. Define ALU_OVF_TRAP_EN for the sticky
// overflow trap that blocks flag-setting requests once set.
//
// state | meaning
// IDLE  | waiting for a request; grant and ready are combinational
// EXEC  | latched operands on the ALU bus; result captured at the edge
// RESP  | response held until rsp_ready
module alu_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input logic        clk,
  input logic        rst,
  alu_share_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic             ptr;      // 1: requester 1 wins a tie
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             setf_q;
  logic             id_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_r_q;
  logic [3:0]       rsp_flags_q;
  logic [3:0]       status_q;
  logic [3:0]       alu_flags;
  logic             blocked0;
  logic             blocked1;
  logic             elig0;
  logic             elig1;
  logic             take0;
  logic             take1;

  assign alu_flags = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};

`ifdef ALU_OVF_TRAP_EN
  logic trap_q;

  assign blocked0     = trap_q & bus.req0_setf;
  assign blocked1     = trap_q & bus.req1_setf;
  assign bus.ovf_trap = trap_q;

  // Sticky trap: an overflowing flag-setting op latches it until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (state == S_EXEC && setf_q && bus.alu_v) begin
      trap_q <= 1'b1;
    end
  end
`else
  assign blocked0 = 1'b0;
  assign blocked1 = 1'b0;
`endif

  // Grant: a lone eligible requester always wins; ties go to the pointer.
  always_comb begin
    elig0 = bus.req0_valid & ~blocked0;
    elig1 = bus.req1_valid & ~blocked1;
    take0 = (state == S_IDLE) & elig0 & (~elig1 | ~ptr);
    take1 = (state == S_IDLE) & elig1 & (~elig0 | ptr);
  end

  assign bus.req0_ready  = take0;
  assign bus.req1_ready  = take1;
  assign bus.alu_op      = (state != S_IDLE) ? op_q : '0;
  assign bus.alu_a       = (state != S_IDLE) ? a_q  : '0;
  assign bus.alu_b       = (state != S_IDLE) ? b_q  : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_r       = rsp_r_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.status_nzcv = status_q;
  assign bus.busy        = (state != S_IDLE);

  // Sequencer: accept, execute for one cycle, hold the response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      setf_q      <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_flags_q <= '0;
      status_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take0 | take1) begin
            op_q   <= take1 ? bus.req1_op   : bus.req0_op;
            a_q    <= take1 ? bus.req1_a    : bus.req0_a;
            b_q    <= take1 ? bus.req1_b    : bus.req0_b;
            setf_q <= take1 ? bus.req1_setf : bus.req0_setf;
            id_q   <= take1;
            ptr    <= take0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_r_q     <= bus.alu_r;
          rsp_flags_q <= alu_flags;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          if (setf_q) begin
            status_q <= alu_flags;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: a driver issues random and directed
// requests and pushes expected responses from a transaction-level model; a
// monitor pops and compares whenever the DUT presents a response.
module tb_alu_share_ctrl;
  localparam logic [3:0] OP_ORR = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_share_if #(.WIDTH(32), .OPW(4)) bus ();
  alu_share_ctrl #(.WIDTH(32), .OPW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  flags;
    logic        id;
    logic [3:0]  status;
    logic        trap;
    int          hcyc;
    bit          seen;
  } exp_t;
  exp_t q[$];

  // transaction-level model state
  bit          m_idle = 1'b1;
  bit          m_ptr = 1'b0;
  bit          m_trap = 1'b0;
  logic [3:0]  m_status = 4'h0;
  int          m_hs = 0;
  logic [3:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;

  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c;
    logic v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'h0), c, v, r};
  endfunction

  // bench ALU datapath
  always_comb begin
    logic [35:0] res;
    res = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
    bus.alu_r = res[31:0];
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = res[35:32];
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // one cycle of stimulus plus model update
  task automatic step(input bit v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0, input bit s0,
                      input bit v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1, input bit s1,
                      input bit rr);
    bit e0, e1, g0, g1, consume, sel, setf;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [35:0] res;
    exp_t it;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_setf = s0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_setf = s1;
    bus.rsp_ready  = rr;
    #1;
    e0 = v0 && !(m_trap && s0);
    e1 = v1 && !(m_trap && s1);
    g0 = m_idle && e0 && (!e1 || !m_ptr);
    g1 = m_idle && e1 && (!e0 || m_ptr);
    check_eq("req0_ready", bus.req0_ready, g0);
    check_eq("req1_ready", bus.req1_ready, g1);
    check_eq("ready_both", bus.req0_ready & bus.req1_ready, 0);
    check_eq("busy", bus.busy, !m_idle);
    if (m_idle) begin
      check_eq("alu_bus_idle", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
    end else if (cyc == m_hs + 1) begin
      check_eq("alu_op_exec", bus.alu_op, m_op);
      check_eq("alu_ab_exec", {bus.alu_a, bus.alu_b}, {m_a, m_b});
    end
    consume = !m_idle && (cyc >= m_hs + 2) && rr;
    if (g0 || g1) begin
      sel  = g1;
      op   = sel ? o1 : o0;
      a    = sel ? a1 : a0;
      b    = sel ? b1 : b0;
      setf = sel ? s1 : s0;
      res  = alu_ref(op, a, b);
      if (setf) m_status = res[35:32];
`ifdef ALU_OVF_TRAP_EN
      m_trap = m_trap | (setf & res[32]);
`endif
      it.r = res[31:0]; it.flags = res[35:32]; it.id = sel; it.status = m_status;
      it.trap = m_trap; it.hcyc = cyc; it.seen = 1'b0;
      q.push_back(it);
      m_ptr = g0; m_idle = 1'b0; m_hs = cyc;
      m_op = op; m_a = a; m_b = b;
    end
    if (consume) m_idle = 1'b1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic req0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit setf, input bit rr);
    step(1, op, a, b, setf, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
    q.delete();
    m_idle = 1'b1; m_ptr = 1'b0; m_trap = 1'b0; m_status = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_status", bus.status_nzcv, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_rsp_data", {bus.rsp_id, bus.rsp_r, bus.rsp_flags}, 0);
`ifdef ALU_OVF_TRAP_EN
    check_eq("rst_ovf_trap", bus.ovf_trap, 0);
`endif
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  // monitor: compare presented responses against the queue head
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          check_eq("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          if (!q[0].seen) begin
            check_eq("rsp_latency", cyc, q[0].hcyc + 2);
            q[0].seen = 1'b1;
          end
          check_eq("rsp_r", bus.rsp_r, q[0].r);
          check_eq("rsp_flags", bus.rsp_flags, q[0].flags);
          check_eq("rsp_id", bus.rsp_id, q[0].id);
          check_eq("status_nzcv", bus.status_nzcv, q[0].status);
`ifdef ALU_OVF_TRAP_EN
          check_eq("ovf_trap", bus.ovf_trap, q[0].trap);
`endif
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].hcyc + 2) begin
        check_eq("rsp_missing", bus.rsp_valid, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_setf = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_setf = 0;
    bus.rsp_ready = 0;
    do_reset();

    // ORR 2|1 -> 3, flags 0000; then Z-setting op; then N result without setf
    req0(OP_ORR, 32'h2, 32'h1, 1, 1);
    idle(3, 1);
    req0(OP_ORR, 32'h0, 32'h0, 1, 1);
    idle(3, 1);
    req0(OP_ORR, 32'h8000_0000, 32'h8000_0000, 0, 1);
    idle(3, 1);
    check_eq("status_after_nosetf", bus.status_nzcv, 4'b0100);

    // both requesters continuously valid: alternating grants
    for (int i = 0; i < 12; i++)
      step(1, OP_ADD, $urandom, $urandom, 0, 1, OP_SUB, $urandom, $urandom, 0, 1);
    idle(3, 1);

    // response back-pressure with requester 1 waiting
    req0(OP_SUB, 32'h5, 32'h7, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, OP_ADD, 32'h1, 32'h1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, OP_ADD, 32'h1, 32'h1, 0, 1);

    // reset while an op is in EXEC, with a nonzero status
    req0(OP_ORR, 32'h0, 32'h0, 1, 1);
    idle(3, 1);
    req0(OP_ADD, 32'h1, 32'h2, 1, 1);
    do_reset();
    idle(4, 1);

`ifdef ALU_OVF_TRAP_EN
    req0(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, 1);
    idle(3, 1);
    check_eq("ovf_trap_set", bus.ovf_trap, 1);
    for (int i = 0; i < 6; i++) req0(OP_ADD, 32'h1, 32'h1, 1, 1);
    req0(OP_ADD, 32'h1, 32'h1, 0, 1);
    idle(4, 1);
    do_reset();
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 6, 4'($urandom_range(1, 4)), rand_word(), rand_word(), 1'($urandom),
           $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), rand_word(), rand_word(), 1'($urandom),
           1'($urandom));
    idle(6, 1);
    check_eq("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
